// File: rtl/nbcac_22di_pkg.sv
// Shared constants, weight table and FSM state type for the 22-bit NBCAC encoder/decoder family.
package nbcac_22di_pkg;

    localparam int unsigned NB_W  = 22;
    localparam int unsigned NB_N  = 31;
    localparam int unsigned R_W   = NB_W + 1;
    localparam int unsigned IDX_W = 5;

    // Numeral weights s1..s31; s1 is the parity bit carried in d[1].
    localparam logic [31:0] NBCAC22_S [1:31] = '{
        32'd1,       32'd1664080, 32'd1028458, 32'd635622, 32'd392836,
        32'd242786,  32'd150050,  32'd92736,   32'd57314,  32'd35422,
        32'd21892,   32'd13530,   32'd8362,    32'd5168,   32'd3194,
        32'd1974,    32'd1220,    32'd754,     32'd466,    32'd288,
        32'd178,     32'd110,     32'd68,      32'd42,     32'd26,
        32'd16,      32'd10,      32'd6,       32'd4,      32'd2,
        32'd2
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nbcac_22di_encoder_seq_if.sv
// Input/output valid-ready bundle of the sequential NBCAC encoder; out_code bit 0 is always 0.
interface nbcac_22di_encoder_seq_if;
    import nbcac_22di_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [NB_W-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [NB_N:0]   out_code;
    logic            err;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_code, err
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_code, err
    );

endinterface

// File: rtl/nbcac_22di_weight_rom.sv
// Combinational index-to-weight lookup; index 0 and out-of-range indices return 0.
module nbcac_22di_weight_rom
    import nbcac_22di_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output logic [R_W-1:0]   weight_c
);

    always_comb begin
        weight_c = '0;
        for (int unsigned k = 1; k <= NB_N; k++) begin
            if (idx == IDX_W'(k)) begin
                weight_c = R_W'(NBCAC22_S[k]);
            end
        end
    end

endmodule

// File: rtl/nbcac_22di_encoder_seq.sv
// Sequential greedy NBCAC encoder: one codeword bit per cycle, valid/ready on both sides.
// Optional residual check enabled by defining NBCAC_ENC_CHECK_EN.
module nbcac_22di_encoder_seq
    import nbcac_22di_pkg::*;
(
    input logic                     clk,
    input logic                     rst,
    nbcac_22di_encoder_seq_if.slave bus
);

    localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(2);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NB_N);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [R_W-1:0]   r_q, r_d;
    logic [NB_N:0]    code_q, code_d;
    logic             err_q, err_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [R_W-1:0]   weight_c;
    logic             ge_c;
    logic [R_W-1:0]   r_sub_c;

    nbcac_22di_weight_rom u_rom (
        .idx      (idx_q),
        .weight_c (weight_c)
    );

    // Single shared comparator/subtractor for the current weight.
    assign ge_c    = (r_q >= weight_c);
    assign r_sub_c = ge_c ? (r_q - weight_c) : r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= IDX_FIRST;
            r_q         <= '0;
            code_q      <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            r_q         <= r_d;
            code_q      <= code_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        r_d     = r_q;
        code_d  = code_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    r_d     = R_W'(bus.in_data);
                    code_d  = '0;
                    idx_d   = IDX_FIRST;
                    err_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                code_d[idx_q] = ge_c;
                r_d           = r_sub_c;
                if (idx_q == IDX_LAST) begin
                    // Leftover after s31 becomes the parity digit d[1].
                    code_d[1] = r_sub_c[0];
                    state_d   = DONE;
`ifdef NBCAC_ENC_CHECK_EN
                    err_d     = (r_sub_c > R_W'(1));
`endif
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    err_d   = 1'b0;
                    idx_d   = IDX_FIRST;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_code  = code_q;
    assign bus.err       = err_q;

endmodule
